// File: rtl/ddr_axi_pkg.sv
// Shared definitions for the DDR command scheduler and its AXI master engine:
// scheduler state encodings, AXI command type codes and the beat size.
package ddr_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_HALT      = 2'd3
  } sched_state_e;

  localparam logic ATYPE_WRITE = 1'b1;
  localparam logic ATYPE_READ  = 1'b0;

  localparam int BEAT_BYTES = 32;

endpackage

// File: rtl/ddr_addr_ptr.sv
// Burst address pointer over a circular DDR region: steps by one burst on
// advance and wraps back to the region start when it reaches the region end.
module ddr_addr_ptr #(
  parameter logic [31:0] START_ADDR = 32'h00000000,
  parameter logic [31:0] STOP_ADDR  = 32'h00100000,
  parameter logic [31:0] STEP       = 32'd512
) (
  input  logic        axi_clk,
  input  logic        rst,
  input  logic        advance,
  output logic [31:0] addr
);

  logic [31:0] addr_reg;
  logic [32:0] sum_next;

  // One extra bit so a region ending at the top of the address space still wraps.
  assign sum_next = {1'b0, addr_reg} + {1'b0, STEP};

  always_ff @(posedge axi_clk) begin
    if (rst) begin
      addr_reg <= START_ADDR;
    end else if (advance) begin
      addr_reg <= (sum_next >= {1'b0, STOP_ADDR}) ? START_ADDR : sum_next[31:0];
    end
  end

  assign addr = addr_reg;

endmodule

// File: rtl/ddr_cmd_sched.sv
// Burst command scheduler: moves data between the word FIFO and a circular DDR
// region, round-robin arbitrating write and read bursts with a completion watchdog.
module ddr_cmd_sched
  import ddr_axi_pkg::*;
#(
  parameter logic [31:0] START_ADDR  = 32'h00000000,
  parameter logic [31:0] STOP_ADDR   = 32'h00100000,
  parameter int          BURST_BEATS = 16,
  parameter logic [15:0] WDOG_CYCLES = 16'd4096
) (
  input  logic        axi_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [6:0]  fifo_count,
  input  logic        rd_en,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_type,
  output logic [31:0] cmd_addr,
  output logic [7:0]  cmd_len,
  input  logic        cmd_done,
  input  logic        cmd_err,
  output logic [31:0] wr_ptr,
  output logic [31:0] rd_ptr,
  output logic [15:0] fill,
  output logic        busy,
  output logic        err,
  output logic        timeout
);

  localparam logic [31:0] BURST_BYTES   = 32'(BURST_BEATS * BEAT_BYTES);
  localparam logic [31:0] REGION_BURSTS = (STOP_ADDR - START_ADDR) / BURST_BYTES;
  localparam logic [15:0] MAX_FILL      = REGION_BURSTS[15:0];
  localparam logic [7:0]  CMD_LEN       = 8'(BURST_BEATS - 1);
  localparam logic [7:0]  BEATS_MIN     = 8'(BURST_BEATS);

  sched_state_e state_reg, state_next;

  logic        cmd_type_reg;
  logic [31:0] cmd_addr_reg;
  logic [7:0]  cmd_len_reg;
  logic [15:0] fill_reg;
  logic [15:0] wdog_reg;
  logic        err_reg;
  logic        timeout_reg;
  logic        last_grant_reg;

  logic        wr_elig;
  logic        rd_elig;
  logic        grant;
  logic        grant_type;
  logic        complete;
  logic        expire;

  // Pointer array indexed by command type: [ATYPE_READ] and [ATYPE_WRITE].
  logic [1:0][31:0] ptr_q;
  logic [1:0]       ptr_adv;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ptr
      assign ptr_adv[gi] = complete && (cmd_type_reg == 1'(gi));

      ddr_addr_ptr #(
        .START_ADDR (START_ADDR),
        .STOP_ADDR  (STOP_ADDR),
        .STEP       (BURST_BYTES)
      ) u_ptr (
        .axi_clk (axi_clk),
        .rst     (rst),
        .advance (ptr_adv[gi]),
        .addr    (ptr_q[gi])
      );
    end
  endgenerate

  assign wr_elig = enable && ({1'b0, fifo_count} >= BEATS_MIN) && (fill_reg < MAX_FILL);
  assign rd_elig = enable && rd_en && (fill_reg != 16'd0);

  always_comb begin
    state_next = state_reg;
    grant      = 1'b0;
    grant_type = ATYPE_READ;
    complete   = 1'b0;
    expire     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (wr_elig || rd_elig) begin
          grant      = 1'b1;
          // Contested grants alternate; otherwise the lone requester wins.
          grant_type = (wr_elig && rd_elig) ? ~last_grant_reg
                                            : (wr_elig ? ATYPE_WRITE : ATYPE_READ);
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          state_next = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (cmd_done) begin
          complete   = 1'b1;
          state_next = ST_IDLE;
        end else if (wdog_reg == WDOG_CYCLES - 16'd1) begin
          expire     = 1'b1;
          state_next = ST_HALT;
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (rst) begin
      cmd_type_reg   <= ATYPE_READ;
      cmd_addr_reg   <= 32'd0;
      cmd_len_reg    <= 8'd0;
      fill_reg       <= 16'd0;
      wdog_reg       <= 16'd0;
      err_reg        <= 1'b0;
      timeout_reg    <= 1'b0;
      last_grant_reg <= ATYPE_READ;
    end else begin
      if (grant) begin
        cmd_type_reg   <= grant_type;
        cmd_addr_reg   <= ptr_q[grant_type];
        cmd_len_reg    <= CMD_LEN;
        last_grant_reg <= grant_type;
      end

      if (state_reg == ST_ISSUE) begin
        wdog_reg <= 16'd0;
      end else if (state_reg == ST_WAIT_DONE) begin
        wdog_reg <= wdog_reg + 16'd1;
      end

      if (complete) begin
        fill_reg <= (cmd_type_reg == ATYPE_WRITE) ? fill_reg + 16'd1 : fill_reg - 16'd1;
        if (cmd_err) begin
          err_reg <= 1'b1;
        end
      end

      if (expire) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  assign cmd_valid = (state_reg == ST_ISSUE);
  assign cmd_type  = cmd_type_reg;
  assign cmd_addr  = cmd_addr_reg;
  assign cmd_len   = cmd_len_reg;
  assign wr_ptr    = ptr_q[ATYPE_WRITE];
  assign rd_ptr    = ptr_q[ATYPE_READ];
  assign fill      = fill_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign err       = err_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_ddr_cmd_sched.sv
// Self-checking bench for ddr_cmd_sched: a transaction-level model checked every
// cycle, plus directed scenarios with hand-computed handshake and pointer values.
module tb_ddr_cmd_sched;

  localparam logic [31:0] START    = 32'h00000000;
  localparam logic [31:0] STOP     = 32'h00100000;
  localparam int          BURST    = 16;
  localparam int          WDOG     = 4096;
  localparam int          BBYTES   = BURST * 32;
  localparam int          MAX_FILL = (STOP - START) / BBYTES;

  logic        axi_clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [6:0]  fifo_count = 7'd0;
  logic        rd_en = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic        cmd_type;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        cmd_done;
  logic        cmd_err;
  logic [31:0] wr_ptr;
  logic [31:0] rd_ptr;
  logic [15:0] fill;
  logic        busy;
  logic        err;
  logic        timeout;

  logic resp_en = 1'b1;
  logic resp_err = 1'b0;
  int   resp_delay = 5;
  int   resp_cnt = 0;
  logic resp_done = 1'b0;
  logic man_done = 1'b0;

  assign cmd_done = resp_done | man_done;
  assign cmd_err  = resp_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 axi_clk = ~axi_clk;

  ddr_cmd_sched #(
    .START_ADDR  (START),
    .STOP_ADDR   (STOP),
    .BURST_BEATS (BURST),
    .WDOG_CYCLES (16'(WDOG))
  ) dut (
    .axi_clk    (axi_clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_count (fifo_count),
    .rd_en      (rd_en),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_type   (cmd_type),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_done   (cmd_done),
    .cmd_err    (cmd_err),
    .wr_ptr     (wr_ptr),
    .rd_ptr     (rd_ptr),
    .fill       (fill),
    .busy       (busy),
    .err        (err),
    .timeout    (timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic        model_live = 1'b0;
  logic        m_out, m_offered, m_halt, m_last_w;
  logic        m_type, m_err, m_to;
  logic [31:0] m_addr, m_wr, m_rd;
  logic [7:0]  m_len;
  int          m_fill, m_wait;

  function automatic logic [31:0] next_burst(input logic [31:0] p);
    longint n;
    n = longint'(p) + BBYTES;
    return (n >= longint'(STOP)) ? START : 32'(n);
  endfunction

  always @(posedge axi_clk) begin : model
    bit w_ok, r_ok, pick_w;
    if (rst) begin
      model_live <= 1'b1;
      m_out <= 1'b0; m_offered <= 1'b0; m_halt <= 1'b0; m_last_w <= 1'b0;
      m_type <= 1'b0; m_addr <= 32'd0; m_len <= 8'd0;
      m_wr <= START; m_rd <= START; m_fill <= 0; m_wait <= 0;
      m_err <= 1'b0; m_to <= 1'b0;
    end else if (m_halt) begin
      m_halt <= 1'b1;
    end else if (!m_out) begin
      w_ok = enable && (int'(fifo_count) >= BURST) && (m_fill < MAX_FILL);
      r_ok = enable && rd_en && (m_fill > 0);
      if (w_ok || r_ok) begin
        pick_w = (w_ok && r_ok) ? !m_last_w : w_ok;
        m_out <= 1'b1; m_offered <= 1'b1; m_last_w <= pick_w;
        m_type <= pick_w; m_addr <= pick_w ? m_wr : m_rd; m_len <= 8'(BURST - 1);
      end
    end else if (m_offered) begin
      if (cmd_ready) begin
        m_offered <= 1'b0;
        m_wait <= 0;
      end
    end else if (cmd_done) begin
      m_out <= 1'b0;
      if (cmd_err) m_err <= 1'b1;
      if (m_type) begin
        m_wr <= next_burst(m_wr);
        m_fill <= m_fill + 1;
      end else begin
        m_rd <= next_burst(m_rd);
        m_fill <= m_fill - 1;
      end
    end else if (m_wait + 1 >= WDOG) begin
      m_halt <= 1'b1;
      m_to <= 1'b1;
    end else begin
      m_wait <= m_wait + 1;
    end
  end

  always @(negedge axi_clk) begin
    if (model_live) begin
      chk("cmd_valid", 32'(cmd_valid), 32'(m_offered));
      chk("cmd_type", 32'(cmd_type), 32'(m_type));
      chk("cmd_addr", cmd_addr, m_addr);
      chk("cmd_len", 32'(cmd_len), 32'(m_len));
      chk("wr_ptr", wr_ptr, m_wr);
      chk("rd_ptr", rd_ptr, m_rd);
      chk("fill", 32'(fill), 32'(m_fill));
      chk("busy", 32'(busy), 32'(m_out | m_halt));
      chk("err", 32'(err), 32'(m_err));
      chk("timeout", 32'(timeout), 32'(m_to));
    end
  end

  // ---------------- engine responder and handshake log ----------------
  typedef struct {
    logic        t;
    logic [31:0] a;
  } hs_t;
  hs_t hs_q[$];

  always @(negedge axi_clk) begin
    if (!rst && cmd_valid && cmd_ready) begin
      hs_q.push_back('{t: cmd_type, a: cmd_addr});
      $display("cmd handshake: %s addr=0x%05h t=%0t", cmd_type ? "W" : "R", cmd_addr, $time);
    end
  end

  always @(negedge axi_clk) begin
    if (rst) begin
      resp_cnt <= 0;
      resp_done <= 1'b0;
    end else begin
      resp_done <= 1'b0;
      if (resp_cnt > 0) begin
        if (resp_cnt == 1) resp_done <= 1'b1;
        resp_cnt <= resp_cnt - 1;
      end else if (resp_en && cmd_valid && cmd_ready) begin
        resp_cnt <= resp_delay;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge axi_clk);
      #1;
    end
  endtask

  task automatic wait_log(input int n, input int budget);
    int k = 0;
    while (hs_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    chk("handshake_within_budget", 32'(hs_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick(1);
      k++;
    end
    chk("idle_within_budget", 32'(busy), 32'd0);
  endtask

  task automatic wait_fill(input int target, input int budget);
    int k = 0;
    while (int'(fill) != target && k < budget) begin
      tick(1);
      k++;
    end
    chk("fill_reached", 32'(fill), 32'(target));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    hs_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(cmd_valid), 32'd0);
    chk({tag, "_type"}, 32'(cmd_type), 32'd0);
    chk({tag, "_addr"}, cmd_addr, 32'd0);
    chk({tag, "_len"}, 32'(cmd_len), 32'd0);
    chk({tag, "_wr_ptr"}, wr_ptr, START);
    chk({tag, "_rd_ptr"}, rd_ptr, START);
    chk({tag, "_fill"}, 32'(fill), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    tick(3);
    chk_reset_outputs("rst0");
    rst = 1'b0;

    // Single write, done 5 cycles after handshake.
    fifo_count = 7'd16; cmd_ready = 1'b1; resp_delay = 5; enable = 1'b1;
    wait_log(1, 50);
    wait_idle(50);
    enable = 1'b0;
    chk("s1_hs_count", 32'(hs_q.size()), 32'd1);
    chk("s1_type", 32'(hs_q[0].t), 32'd1);
    chk("s1_addr", hs_q[0].a, 32'h0);
    chk("s1_wr_ptr", wr_ptr, 32'h200);
    chk("s1_fill", 32'(fill), 32'd1);

    // One beat short of a burst: no write; a stray done while idle is ignored.
    fifo_count = 7'd15; enable = 1'b1;
    tick(10);
    man_done = 1'b1;
    tick(1);
    man_done = 1'b0;
    tick(2);
    enable = 1'b0;
    chk("s1_short_hs_count", 32'(hs_q.size()), 32'd1);
    chk("s1_stray_fill", 32'(fill), 32'd1);

    // Both eligible: W,R,W,R from reset.
    do_reset();
    fifo_count = 7'd16; rd_en = 1'b1; resp_delay = 2; enable = 1'b1;
    wait_log(4, 200);
    wait_idle(50);
    enable = 1'b0;
    chk("rr_t0", 32'(hs_q[0].t), 32'd1);
    chk("rr_t1", 32'(hs_q[1].t), 32'd0);
    chk("rr_t2", 32'(hs_q[2].t), 32'd1);
    chk("rr_t3", 32'(hs_q[3].t), 32'd0);
    chk("rr_a2", hs_q[2].a, 32'h200);
    chk("rr_a3", hs_q[3].a, 32'h200);
    chk("rr_fill", 32'(fill), 32'd0);

    // Backpressure: ready low 10 cycles, then ready with enable already dropped.
    rd_en = 1'b0; cmd_ready = 1'b0; enable = 1'b1;
    tick(2);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(cmd_valid), 32'd1);
      chk("bp_addr", cmd_addr, 32'h400);
      chk("bp_type", 32'(cmd_type), 32'd1);
      tick(1);
    end
    n = hs_q.size();
    cmd_ready = 1'b1; enable = 1'b0;
    wait_idle(50);
    chk("bp_hs_count", 32'(hs_q.size()), 32'(n + 1));
    chk("bp_wr_ptr", wr_ptr, 32'h600);

    // Read completing with an error response; err stays set afterwards.
    resp_err = 1'b1; rd_en = 1'b1; fifo_count = 7'd0; enable = 1'b1;
    wait_log(n + 2, 50);
    enable = 1'b0;
    wait_idle(50);
    resp_err = 1'b0;
    chk("er_type", 32'(hs_q[n + 1].t), 32'd0);
    chk("er_addr", hs_q[n + 1].a, 32'h400);
    chk("er_err", 32'(err), 32'd1);
    chk("er_rd_ptr", rd_ptr, 32'h600);
    chk("er_fill", 32'(fill), 32'd0);
    fifo_count = 7'd16; enable = 1'b1;
    wait_log(n + 3, 50);
    enable = 1'b0;
    wait_idle(50);
    chk("er_sticky", 32'(err), 32'd1);
    do_reset();
    chk("er_cleared", 32'(err), 32'd0);

    // Fill the whole region: last write from 0xFFE00 wraps wr_ptr to 0.
    rd_en = 1'b0; fifo_count = 7'd16; resp_delay = 1; enable = 1'b1;
    wait_fill(MAX_FILL, 12000);
    chk("wrap_last_addr", hs_q[hs_q.size() - 1].a, 32'hFFE00);
    chk("wrap_wr_ptr", wr_ptr, 32'h0);
    n = hs_q.size();
    tick(20);
    chk("full_blocks_write", 32'(hs_q.size()), 32'(n));
    rd_en = 1'b1;
    wait_log(n + 2, 50);
    wait_idle(50);
    enable = 1'b0;
    chk("full_read_type", 32'(hs_q[n].t), 32'd0);
    chk("wrap_next_type", 32'(hs_q[n + 1].t), 32'd1);
    chk("wrap_next_addr", hs_q[n + 1].a, 32'h0);

    // Watchdog: engine never completes.
    do_reset();
    resp_en = 1'b0; rd_en = 1'b0; cmd_ready = 1'b1; enable = 1'b1;
    wait_log(1, 20);
    enable = 1'b0;
    tick(WDOG - 1);
    chk("wd_not_yet", 32'(timeout), 32'd0);
    tick(1);
    chk("wd_timeout", 32'(timeout), 32'd1);
    chk("wd_busy", 32'(busy), 32'd1);
    man_done = 1'b1;
    tick(1);
    man_done = 1'b0;
    tick(3);
    chk("halt_holds", 32'(busy), 32'd1);
    chk("halt_fill", 32'(fill), 32'd0);
    rst = 1'b1;
    tick(1);
    chk_reset_outputs("rst_in");
    rst = 1'b0;
    tick(1);
    chk_reset_outputs("rst_out");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
